// File: rtl/tdm_pkg.sv
// Shared constants and types for the eight-slot TDM demultiplexer.
package tdm_pkg;
   localparam int NSLOTS = 8;
   localparam int SLOT_W = 3;

   typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOTS - 1);
endpackage

// File: rtl/tdm_demux8_if.sv
// Serial-in / frame-out bus of the TDM demultiplexer.
interface tdm_demux8_if;
   import tdm_pkg::*;

   logic              din;
   logic              en;
   logic              sync;
   logic [NSLOTS-1:0] f;
   logic              valid;
   logic [SLOT_W-1:0] slot;
   logic              locked;
   logic              err;

   // Stream source side: drives the serial bits, observes recovered frames.
   modport master (output din, en, sync, input f, valid, slot, locked, err);
   // Demultiplexer side.
   modport slave  (input din, en, sync, output f, valid, slot, locked, err);
endinterface

// File: rtl/demux1to8.sv
// 3-to-8 one-hot write-enable decoder; inverse of the 8:1 select mux.
module demux1to8
   import tdm_pkg::*;
(
   input  logic              en,
   input  logic [SLOT_W-1:0] slot,
   output logic [NSLOTS-1:0] we
);
   // One-hot enable for the addressed slot, all-zero when idle.
   always_comb begin
      we = '0;
      if (en) we[slot] = 1'b1;
   end
endmodule

// File: rtl/tdm_demux8.sv
// Eight-slot TDM demultiplexer: HUNT/RUN framing FSM, slot counter,
// shadow register collecting a frame, and a parallel output register
// that is only loaded with a complete frame.
module tdm_demux8
   import tdm_pkg::*;
#(
   parameter bit SYNC_EACH_FRAME = 1'b1
)(
   input  logic       clk,
   input  logic       resetn,
   tdm_demux8_if.slave bus
);
   state_t            state_q, state_n;
   logic [SLOT_W-1:0] slot_q, slot_n;
   logic [NSLOTS-1:0] shadow_q, shadow_n;
   logic [NSLOTS-1:0] f_q, f_n;
   logic              valid_n, err_n, valid_q, err_q;
   logic              wr_en;
   logic [SLOT_W-1:0] wr_slot;
   logic [NSLOTS-1:0] we;

   // Framing decisions: where (if anywhere) din lands, and what happens to slot/state.
   always_comb begin
      state_n = state_q;
      slot_n  = slot_q;
      f_n     = f_q;
      valid_n = 1'b0;
      err_n   = 1'b0;
      wr_en   = 1'b0;
      wr_slot = '0;
      if (bus.en) begin
         unique case (state_q)
            HUNT: begin
               if (bus.sync) begin
                  wr_en   = 1'b1;
                  slot_n  = SLOT_W'(1);
                  state_n = RUN;
               end
            end
            RUN: begin
               if (bus.sync && slot_q != '0) begin
                  // Resync beats everything, including a slot-7 completion.
                  err_n  = 1'b1;
                  wr_en  = 1'b1;
                  slot_n = SLOT_W'(1);
               end else if (SYNC_EACH_FRAME && !bus.sync && slot_q == '0) begin
                  err_n   = 1'b1;
                  slot_n  = '0;
                  state_n = HUNT;
               end else begin
                  wr_en   = 1'b1;
                  wr_slot = slot_q;
                  slot_n  = slot_q + SLOT_W'(1);
                  if (slot_q == LAST_SLOT) begin
                     f_n     = {bus.din, shadow_q[NSLOTS-2:0]};
                     valid_n = 1'b1;
                  end
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   demux1to8 u_dec (.en(wr_en), .slot(wr_slot), .we(we));

   // Shadow bits take din only where the decoder points; the rest hold.
   always_comb begin
      shadow_n = shadow_q;
      for (int k = 0; k < NSLOTS; k++)
         if (we[k]) shadow_n[k] = bus.din;
   end

   // State, counter, shadow and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= HUNT;
         slot_q   <= '0;
         shadow_q <= '0;
         f_q      <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_n;
         slot_q   <= slot_n;
         shadow_q <= shadow_n;
         f_q      <= f_n;
         valid_q  <= valid_n;
         err_q    <= err_n;
      end
   end

   assign bus.f      = f_q;
   assign bus.valid  = valid_q;
   assign bus.err    = err_q;
   assign bus.slot   = slot_q;
   assign bus.locked = (state_q == RUN);
endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: directed scenarios plus random traffic, every
// output compared each cycle against a frame-level reference model.
module tb_tdm_demux8;
   logic clk = 1'b0;
   logic resetn;
   int   n_chk = 0;
   int   n_fail = 0;

   tdm_demux8_if bus ();
   tdm_demux8 #(.SYNC_EACH_FRAME(1'b1)) dut (.clk(clk), .resetn(resetn), .bus(bus));

   always #5 clk = ~clk;

   // Reference model: locked flag, next write position, collected bits.
   bit       m_locked;
   int       m_pos;
   bit       m_bits [8];
   bit [7:0] m_f;
   bit       m_valid, m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_pos = 0; m_f = 8'h00; m_valid = 0; m_err = 0;
      foreach (m_bits[k]) m_bits[k] = 0;
   endtask

   task automatic model_step(input bit en, input bit sy, input bit d);
      m_valid = 0; m_err = 0;
      if (!en) return;
      if (!m_locked) begin
         if (sy) begin m_bits[0] = d; m_pos = 1; m_locked = 1; end
      end else if (sy && m_pos != 0) begin
         m_err = 1; m_bits[0] = d; m_pos = 1;
      end else if (!sy && m_pos == 0) begin
         m_err = 1; m_locked = 0;
      end else begin
         m_bits[m_pos] = d;
         if (m_pos == 7) begin
            for (int k = 0; k < 8; k++) m_f[k] = m_bits[k];
            m_valid = 1; m_pos = 0;
         end else m_pos++;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".f"},      bus.f,      m_f);
      chk({tag, ".valid"},  bus.valid,  m_valid);
      chk({tag, ".err"},    bus.err,    m_err);
      chk({tag, ".slot"},   bus.slot,   m_pos);
      chk({tag, ".locked"}, bus.locked, m_locked);
      chk({tag, ".excl"},   bus.valid & bus.err, 0);
   endtask

   task automatic step(input bit en, input bit sy, input bit d, input string tag);
      bus.en = en; bus.sync = sy; bus.din = d;
      @(posedge clk);
      model_step(en, sy, d);
      #1;
      check_all(tag);
   endtask

   task automatic send_frame(input logic [7:0] w, input bit gaps, input string tag);
      for (int k = 0; k < 8; k++) begin
         if (gaps) step(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), {tag, ".gap"});
         step(1'b1, k == 0, w[k], tag);
      end
   endtask

   initial begin
      model_reset();
      resetn = 1'b0; bus.en = 0; bus.sync = 0; bus.din = 0;
      #12;
      check_all("reset");
      resetn = 1'b1;

      // Clean frame 8'hB8.
      send_frame(8'hB8, 1'b0, "clean");
      chk("clean.f_const", bus.f, 8'hB8);
      chk("clean.valid_const", bus.valid, 1);
      chk("clean.locked_const", bus.locked, 1);

      // Back-to-back frames.
      send_frame(8'hA5, 1'b0, "b2b0");
      chk("b2b0.f_const", bus.f, 8'hA5);
      chk("b2b0.slot0", bus.slot, 0);
      send_frame(8'h3C, 1'b0, "b2b1");
      chk("b2b1.f_const", bus.f, 8'h3C);
      chk("b2b1.slot0", bus.slot, 0);

      // Frame with en gaps.
      send_frame(8'h5A, 1'b1, "gaps");
      chk("gaps.f_const", bus.f, 8'h5A);

      // Resync at slot 4, then seven bits complete a new frame.
      for (int k = 0; k < 4; k++) step(1'b1, k == 0, 1'b1, "pre_resync");
      step(1'b1, 1'b1, 1'b1, "resync");
      chk("resync.err_const", bus.err, 1);
      chk("resync.slot1", bus.slot, 1);
      chk("resync.f_hold", bus.f, 8'h5A);
      for (int k = 1; k < 8; k++) step(1'b1, 1'b0, k[0], "post_resync");
      chk("post_resync.f_const", bus.f, 8'hAB);

      // Sync coinciding with the slot-7 bit: resync wins.
      for (int k = 0; k < 7; k++) step(1'b1, k == 0, 1'b0, "s7_pre");
      step(1'b1, 1'b1, 1'b1, "s7_sync");
      chk("s7_sync.nov", bus.valid, 0);
      chk("s7_sync.f_hold", bus.f, 8'hAB);
      for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 1'b0, "s7_fill");

      // Lost lock: slot-0 bit without sync.
      step(1'b1, 1'b0, 1'b1, "lost");
      chk("lost.locked_const", bus.locked, 0);
      chk("lost.err_const", bus.err, 1);
      for (int k = 0; k < 10; k++) step(1'b1, 1'b0, $urandom_range(0, 1), "hunt");
      chk("hunt.f_hold", bus.f, 8'h01);

      // Async reset at slot 5.
      for (int k = 0; k < 5; k++) step(1'b1, k == 0, 1'b1, "pre_rst");
      #2 resetn = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      chk("async_rst.f0", bus.f, 0);
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 12; k++) step(1'b1, 1'b0, $urandom_range(0, 1), "post_rst");

      // Random traffic: sync mostly on frame boundaries, occasionally stray.
      for (int i = 0; i < 400; i++) begin
         bit e, s;
         e = ($urandom_range(0, 3) != 0);
         s = ((m_pos == 0) && ($urandom_range(0, 7) != 0)) || ($urandom_range(0, 31) == 0);
         step(e, s, $urandom_range(0, 1), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Eight-slot time-division demultiplexer: the receiving end of the 8:1 select-mux datapath. It takes a serial bit stream in which each bit belongs to one of eight slots (slot 0 flagged by a sync strobe) and routes each bit to its slot position. When a frame completes, it presents all eight bits in parallel. It sits after any serialiser built on an 8:1 mux with a 3-bit rolling select and recovers the original 8-bit word w.

## Interface
- SYNC_EACH_FRAME, 1, 1: sync must accompany slot 0 of every frame; 0: sync is needed only to acquire lock from HUNT.
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- din  in  1  serial data bit for the current slot.
- en  in  1  din valid this cycle; the slot advances only when en=1.
- sync  in  1  qualifies din as slot 0; ignored when en=0.
- f  out  8  last complete frame; f[k] = bit received in slot k.
- valid  out  1  one-cycle pulse: f updated with a new frame.
- slot  out  3  slot index the next en bit will be written to.
- locked  out  1  1 in RUN, 0 in HUNT.
- err  out  1  one-cycle pulse on a framing error.

## Operation
- States: HUNT, RUN. Reset enters HUNT.
- HUNT:
  - en=1 with sync=0: bit discarded.
  - en=1 with sync=1: shadow[0]=din, slot=1, enter RUN.
- RUN, en=1, normal case: shadow[slot]=din, slot=slot+1 (3-bit wrap 7→0).
- RUN, en=1, slot=7:
  - f={din, shadow[6:0]}, valid=1, slot=0.
  - Shadow is not cleared.
- RUN, en=1, sync=1, slot≠0: resync.
  - err=1, partial frame discarded.
  - shadow[0]=din, slot=1, stay RUN.
  - No valid pulse.
- RUN, en=1, sync=0, slot=0, SYNC_EACH_FRAME=1: lost lock.
  - err=1, bit discarded, enter HUNT, slot=0.
- SYNC_EACH_FRAME=0: sync at slot 0 is optional; sync at slot≠0 still resyncs with err.
- en=0: no state, slot, or shadow change; valid and err low.
- f holds its value between frames and is never partially updated.

## Timing
- Reset values: f=8'h00, valid=0, err=0, slot=0, locked=0, shadow=0, state HUNT. Reset asserted mid-frame discards the frame immediately.
- All outputs are registered.
- Latency: f and valid update on the clk edge that samples the slot-7 bit, so they are visible the cycle after that en.
- Back-to-back frames (en held high, sync every 8th cycle): valid pulses every 8 cycles with no bubble.
- Simultaneous sync and slot-7 bit: resync wins. err=1, valid=0, f unchanged.
- err and valid are never high in the same cycle.
- slot reflects the next write position: it reads 0 in HUNT and after each completed frame.
- Minimum frame time: 8 en cycles. Throughput: 1 bit/clk.

## Structure
- Package tdm_pkg:
  - NSLOTS=8, SLOT_W=3.
  - State enum {HUNT, RUN}.
- Sub-module demux1to8: combinational 3-to-8 one-hot write-enable decoder, with inputs (en, slot) and output we[7:0]. It is the inverse of the 8:1 select mux.
- Top holds the FSM, slot counter, shadow register, and output register.

## Test plan
- Reset then clean frame: sync+din=0 at slot 0, then bits of 8'hB8 for slots 1..7 (en=1 each cycle) → valid pulse after the 8th bit, f=8'hB8, err=0, locked=1.
- Two back-to-back frames 8'hA5 then 8'h3C, en continuous → valid exactly 8 cycles apart, f=8'hA5 then 8'h3C, slot reads 0 after each.
- en gaps: frame 8'h5A with en=0 on alternate cycles → same f=8'h5A, valid once, slot holds during gaps.
- Resync: sync asserted at slot 4 mid-frame → err pulse, no valid, slot=1 next; the following 7 bits complete a new frame with valid.
- Lost lock (SYNC_EACH_FRAME=1): slot-0 bit without sync → err, locked=0, f unchanged; bits ignored until the next sync.
- Async reset asserted at slot 5 → f=0, slot=0, locked=0 immediately; after release, bits without sync produce no valid.
